// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with a safe period-change handshake.
// clk_out is produced from a phase counter: a low phase of (period - period/2)
// cycles followed by a high phase of period/2 cycles. New periods are only
// applied at a high->low transition (or on stopping), so the output never
// shows a runt pulse. All outputs come straight from registers.
//
// Configuration handshake: a transfer happens on any cycle where
// cfg_valid && cfg_ready; cfg_ready depends on state only (low while a period
// change is pending); cfg_valid may be raised or dropped at any time; a
// transfer with cfg_period < 2 is consumed and answered with a one-cycle
// cfg_err pulse on the following cycle.
module clk_div_ctrl #(
    parameter int PW             = 8,
    parameter int DEFAULT_PERIOD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          cfg_valid,
    input  logic [PW-1:0] cfg_period,
    output logic          cfg_ready,
    output logic          cfg_err,
    output logic          clk_out,
    output logic          rise_tick,
    output logic          fall_tick,
    output logic          running,
    output logic [PW-1:0] cur_period,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pend_q, pend_d;
    logic [PW-1:0] cur_q, cur_d;
    logic          clk_q, clk_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          err_q, err_d;

    logic [PW-1:0] high_len;
    logic [PW-1:0] low_len;
    logic [PW-1:0] phase_last;
    logic [PW-1:0] base_period;
    logic          at_end;
    logic          xfer;
    logic          legal;
    logic          take;

    // Phase bookkeeping and handshake decode.
    always_comb begin
        high_len    = cur_q >> 1;
        low_len     = cur_q - high_len;
        phase_last  = clk_q ? (high_len - PW'(1)) : (low_len - PW'(1));
        at_end      = (cnt_q == phase_last);
        xfer        = cfg_valid && (state_q != ST_PEND);
        legal       = (cfg_period >= PW'(2));
        take        = xfer && legal;
        // Period that takes effect when the current cycle ends a period.
        base_period = (state_q == ST_PEND) ? pend_q : cur_q;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        cur_d   = cur_q;
        clk_d   = clk_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        err_d   = xfer && !legal;

        case (state_q)
            ST_STOP: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (take) cur_d = cfg_period;
                if (en) state_d = ST_RUN;
            end
            ST_RUN, ST_PEND: begin
                if (!clk_q && !en) begin
                    // Stopping in a low phase: truncate it, no high pulse.
                    state_d = ST_STOP;
                    cnt_d   = '0;
                    cur_d   = take ? cfg_period : base_period;
                end else if (at_end) begin
                    cnt_d  = '0;
                    clk_d  = !clk_q;
                    rise_d = !clk_q;
                    fall_d = clk_q;
                    if (clk_q) begin
                        // End of a full period: pending period takes effect.
                        cur_d = base_period;
                        if (!en) begin
                            state_d = ST_STOP;
                            if (take) cur_d = cfg_period;
                        end else if (take) begin
                            pend_d  = cfg_period;
                            state_d = ST_PEND;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (take) begin
                        pend_d  = cfg_period;
                        state_d = ST_PEND;
                    end
                end else begin
                    cnt_d = cnt_q + PW'(1);
                    if (take) begin
                        pend_d  = cfg_period;
                        state_d = ST_PEND;
                    end
                end
            end
            default: begin
                state_d = ST_STOP;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
            cnt_q   <= '0;
            pend_q  <= '0;
            cur_q   <= PW'(DEFAULT_PERIOD);
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            cur_q   <= cur_d;
            clk_q   <= clk_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            err_q   <= err_d;
        end
    end

    assign cfg_ready  = (state_q != ST_PEND);
    assign cfg_err    = err_q;
    assign clk_out    = clk_q;
    assign rise_tick  = rise_q;
    assign fall_tick  = fall_q;
    assign running    = (state_q != ST_STOP);
    assign cur_period = cur_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter PW, default 8: width of period values and internal counter.
REQ-002 SHALL have parameter DEFAULT_PERIOD, default 8: period loaded at reset, legal range 2..2^PW-1.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  run request; level-sensitive.
REQ-006 SHALL have port cfg_valid  input  1  new period offered.
REQ-007 SHALL have port cfg_period  input  PW  offered period in clk cycles.
REQ-008 SHALL have port cfg_ready  output  1  controller can accept a configuration.
REQ-009 SHALL have port cfg_err  output  1  one-cycle pulse, rejected configuration.
REQ-010 SHALL have port clk_out  output  1  divided clock, registered.
REQ-011 SHALL have port rise_tick  output  1  high only in the first cycle clk_out is 1.
REQ-012 SHALL have port fall_tick  output  1  high only in the first cycle clk_out is 0 after a high phase.
REQ-013 SHALL have port running  output  1  high in states RUN and PEND.
REQ-014 SHALL have port cur_period  output  PW  period currently in effect.

Function
REQ-015 SHALL implement states STOP, RUN, PEND; internal registers: counter (PW bits), pend_period (PW bits).
REQ-016 Phase lengths SHALL be high = cur_period>>1, low = cur_period - high (odd periods: low phase one cycle longer); full period exactly cur_period cycles.
REQ-017 In STOP: clk_out=0, counter=0, ticks 0; en=1 SHALL move to RUN at next edge.
REQ-018 In RUN/PEND: counter increments each cycle; when counter equals current phase length-1, clk_out toggles and counter clears at the same edge.
REQ-019 First phase after STOP->RUN SHALL be a low phase of full length, so first rising edge of clk_out occurs low cycles after entering RUN.
REQ-020 Handshake: transfer occurs on a cycle with cfg_valid=1 and cfg_ready=1; cfg_ready SHALL be 1 in STOP and RUN, 0 in PEND.
REQ-021 Transfer with cfg_period<2 SHALL be consumed without effect and cfg_err SHALL pulse high for exactly one cycle on the next cycle.
REQ-022 Legal transfer in STOP SHALL update cur_period at that edge; if en=1 in that same cycle, RUN starts using the new period.
REQ-023 Legal transfer in RUN SHALL store pend_period and enter PEND; cur_period unchanged.
REQ-024 In PEND, at the edge where clk_out toggles 1->0, cur_period SHALL load pend_period, counter clears, state returns to RUN (or STOP if en=0); the following low phase uses the new period.
REQ-025 Transfer in the same cycle as a 1->0 toggle SHALL NOT apply at that toggle; it applies at the next 1->0 toggle.
REQ-026 en=0 in RUN/PEND with clk_out=1: SHALL complete the high phase, then enter STOP at the 1->0 toggle (pending period applied).
REQ-027 en=0 in RUN/PEND with clk_out=0: SHALL enter STOP at next edge (pending period applied); no high pulse shorter than a full high phase ever occurs.
REQ-028 clk_out SHALL never produce a high pulse shorter than high or a low pulse of RUN shorter than low, except low truncation on stop.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to clk_out, ticks, running, cur_period; cfg_ready depends on state only.

Reset
REQ-030 rst_n=0 SHALL immediately force STOP, counter=0, pend_period=0, clk_out=0, rise_tick=0, fall_tick=0, cfg_err=0, running=0, cfg_ready=1, cur_period=DEFAULT_PERIOD.
REQ-031 Reset asserted mid-operation (any state, any phase) SHALL abort without completing the current phase; pending configuration is discarded.

Verification
REQ-032 Reset release, en=1 held, default period 8 -> clk_out low 4 cycles then high 4 cycles, repeating; rise_tick/fall_tick single-cycle at each transition.
REQ-033 RUN at period 8, offer cfg_period=5 mid high phase -> cfg_ready 0 until next fall; then low 3, high 2 cycles; cur_period reads 5 from fall edge.
REQ-034 cfg_period=1 and cfg_period=0 offered in RUN -> cfg_err one-cycle pulse each, cur_period stays 8, state remains RUN.
REQ-035 en dropped 1 cycle into a 4-cycle high phase -> clk_out stays high 3 more cycles, falls, running=0 next; en dropped in low phase -> running=0 next edge, clk_out stays 0.
REQ-036 cfg transfer coincident with fall_tick-producing edge, cfg_period=6 -> applied at following fall; assert rst_n low mid-PEND -> cur_period=8, pending lost.
